// File: rtl/stitch_pkg.sv
// Shared definitions for the stitch write scheduler: channel count, AXI response
// codes and the scheduler state encoding.
package stitch_pkg;

  localparam int NUM_CH = 3;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AW   = 2'd1,
    ST_W    = 2'd2,
    ST_B    = 2'd3
  } wr_state_e;

endpackage

// File: rtl/rr_arbiter3.sv
// Three-way round-robin arbiter: combinational one-hot grant, priority rotates to
// the channel after the last one granted whenever update is asserted.
module rr_arbiter3
  import stitch_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_CH-1:0] req,
  input  logic              update,
  output logic [NUM_CH-1:0] gnt
);

  logic [NUM_CH-1:0] last_q;

  // Reset state points at channel 2 so channel 0 has first priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 3'b100;
    end else if (update && (|gnt)) begin
      last_q <= gnt;
    end
  end

  always_comb begin
    gnt = '0;
    case (last_q)
      3'b001: begin
        if      (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
      end
      3'b010: begin
        if      (req[2]) gnt = 3'b100;
        else if (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
      end
      default: begin
        if      (req[0]) gnt = 3'b001;
        else if (req[1]) gnt = 3'b010;
        else if (req[2]) gnt = 3'b100;
      end
    endcase
  end

endmodule

// File: rtl/stitch_wr_scheduler.sv
// Schedules fixed-length AXI write bursts from three channel FIFOs into per-channel
// frame buffers, one burst outstanding at a time, round-robin between channels.
module stitch_wr_scheduler
  import stitch_pkg::*;
#(
  parameter int               BURST_LEN = 32,
  parameter int               DATA_W    = 128,
  parameter int               ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] BASE_ADDR = 32'h10000000,
  parameter logic [ADDR_W-1:0] CH_STRIDE = 32'h00800000
) (
  input  logic                     M_AXI_ACLK,
  input  logic                     M_AXI_ARESETN,
  input  logic [NUM_CH-1:0]        ch_req,
  input  logic [NUM_CH-1:0]        ch_frame_start,
  input  logic [NUM_CH*DATA_W-1:0] ch_data,
  output logic [NUM_CH-1:0]        ch_rd_en,
  output logic [ADDR_W-1:0]        M_AXI_AWADDR,
  output logic [7:0]               M_AXI_AWLEN,
  output logic                     M_AXI_AWVALID,
  input  logic                     M_AXI_AWREADY,
  output logic [DATA_W-1:0]        M_AXI_WDATA,
  output logic [DATA_W/8-1:0]      M_AXI_WSTRB,
  output logic                     M_AXI_WLAST,
  output logic                     M_AXI_WVALID,
  input  logic                     M_AXI_WREADY,
  input  logic [1:0]               M_AXI_BRESP,
  input  logic                     M_AXI_BVALID,
  output logic                     M_AXI_BREADY,
  output logic [NUM_CH-1:0]        grant,
  output logic                     wr_err
);

  localparam int                BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT   = BEAT_W'(BURST_LEN - 1);
  localparam logic [ADDR_W-1:0] BURST_BYTES = ADDR_W'(BURST_LEN * DATA_W / 8);

  // Next write offset within a channel buffer, wrapping at the channel stride.
  function automatic logic [ADDR_W-1:0] ptr_advance(input logic [ADDR_W-1:0] ptr);
    logic [ADDR_W:0] sum;
    logic [ADDR_W:0] wrapped;
    sum     = {1'b0, ptr} + {1'b0, BURST_BYTES};
    wrapped = sum - {1'b0, CH_STRIDE};
    return (sum >= {1'b0, CH_STRIDE}) ? wrapped[ADDR_W-1:0] : sum[ADDR_W-1:0];
  endfunction

  wr_state_e         state_q, state_d;
  logic [NUM_CH-1:0] grant_q;
  logic [NUM_CH-1:0] arb_gnt;
  logic              arb_update;
  logic [BEAT_W-1:0] beat_q;
  logic [ADDR_W-1:0] ptr_q [NUM_CH];
  logic [NUM_CH-1:0] pend_q;
  logic              wr_err_q;
  logic              last_beat, b_hs;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;

  assign last_beat  = (beat_q == LAST_BEAT);
  assign b_hs       = (state_q == ST_B) && M_AXI_BVALID;
  assign arb_update = (state_q == ST_IDLE) && (|ch_req);

  rr_arbiter3 u_arb (
    .clk    (M_AXI_ACLK),
    .rst_n  (M_AXI_ARESETN),
    .req    (ch_req),
    .update (arb_update),
    .gnt    (arb_gnt)
  );

  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (|ch_req)                     state_d = ST_AW;
      ST_AW:   if (M_AXI_AWREADY)               state_d = ST_W;
      ST_W:    if (M_AXI_WREADY && last_beat)   state_d = ST_B;
      ST_B:    if (M_AXI_BVALID)                state_d = ST_IDLE;
      default:                                  state_d = ST_IDLE;
    endcase
  end

  // Burst bookkeeping: owner, beat count, per-channel pointers and frame restarts.
  always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
    if (!M_AXI_ARESETN) begin
      grant_q  <= '0;
      beat_q   <= '0;
      pend_q   <= '0;
      wr_err_q <= 1'b0;
      for (int n = 0; n < NUM_CH; n++) ptr_q[n] <= '0;
    end else begin
      if (arb_update) grant_q <= arb_gnt;
      else if (b_hs)  grant_q <= '0;

      if ((state_q == ST_W) && M_AXI_WREADY) beat_q <= last_beat ? '0 : beat_q + BEAT_W'(1);

      wr_err_q <= b_hs && (M_AXI_BRESP != RESP_OKAY);

      // A restart on the owning channel is deferred to its response so the
      // in-flight burst address is never disturbed.
      for (int n = 0; n < NUM_CH; n++) begin
        if (b_hs && grant_q[n]) begin
          ptr_q[n]  <= (pend_q[n] || ch_frame_start[n]) ? '0 : ptr_advance(ptr_q[n]);
          pend_q[n] <= 1'b0;
        end else if (ch_frame_start[n]) begin
          if (grant_q[n]) pend_q[n] <= 1'b1;
          else            ptr_q[n]  <= '0;
        end
      end
    end
  end

  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    for (int n = 0; n < NUM_CH; n++) begin
      if (grant_q[n]) begin
        sel_addr = BASE_ADDR + CH_STRIDE * ADDR_W'(n) + ptr_q[n];
        sel_data = ch_data[n*DATA_W +: DATA_W];
      end
    end
  end

  assign M_AXI_AWLEN   = 8'(BURST_LEN - 1);
  assign M_AXI_WSTRB   = '1;
  assign M_AXI_AWVALID = (state_q == ST_AW);
  assign M_AXI_AWADDR  = (state_q == ST_AW) ? sel_addr : '0;
  assign M_AXI_WVALID  = (state_q == ST_W);
  assign M_AXI_WDATA   = (state_q == ST_W) ? sel_data : '0;
  assign M_AXI_WLAST   = (state_q == ST_W) && last_beat;
  assign M_AXI_BREADY  = (state_q == ST_B);
  assign ch_rd_en      = ((state_q == ST_W) && M_AXI_WREADY) ? grant_q : '0;
  assign grant         = grant_q;
  assign wr_err        = wr_err_q;

endmodule

// File: tb/tb_stitch_wr_scheduler.sv
// Directed-plus-random bench for stitch_wr_scheduler against a burst-level reference model.
module tb_stitch_wr_scheduler;
  import stitch_pkg::*;

  localparam int          BL     = 32;
  localparam int          DW     = 128;
  localparam int          AWD    = 32;
  localparam logic [31:0] BASE   = 32'h10000000;
  localparam logic [31:0] STRIDE = 32'h00001000;
  localparam logic [31:0] BYTES  = 32'(BL * DW / 8);

  logic            clk;
  logic            rst_n;
  logic [2:0]      ch_req;
  logic [2:0]      ch_frame_start;
  logic [3*DW-1:0] ch_data;
  logic [2:0]      ch_rd_en;
  logic [AWD-1:0]  awaddr;
  logic [7:0]      awlen;
  logic            awvalid, awready;
  logic [DW-1:0]   wdata;
  logic [DW/8-1:0] wstrb;
  logic            wlast, wvalid, wready;
  logic [1:0]      bresp;
  logic            bvalid, bready;
  logic [2:0]      grant;
  logic            wr_err;

  stitch_wr_scheduler #(
    .BURST_LEN (BL),
    .DATA_W    (DW),
    .ADDR_W    (AWD),
    .BASE_ADDR (BASE),
    .CH_STRIDE (STRIDE)
  ) dut (
    .M_AXI_ACLK     (clk),
    .M_AXI_ARESETN  (rst_n),
    .ch_req         (ch_req),
    .ch_frame_start (ch_frame_start),
    .ch_data        (ch_data),
    .ch_rd_en       (ch_rd_en),
    .M_AXI_AWADDR   (awaddr),
    .M_AXI_AWLEN    (awlen),
    .M_AXI_AWVALID  (awvalid),
    .M_AXI_AWREADY  (awready),
    .M_AXI_WDATA    (wdata),
    .M_AXI_WSTRB    (wstrb),
    .M_AXI_WLAST    (wlast),
    .M_AXI_WVALID   (wvalid),
    .M_AXI_WREADY   (wready),
    .M_AXI_BRESP    (bresp),
    .M_AXI_BVALID   (bvalid),
    .M_AXI_BREADY   (bready),
    .grant          (grant),
    .wr_err         (wr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Stimulus knobs: ready modes 0 = always high, 1 = toggle, 2 = random.
  logic [2:0] req_fix   = '0;
  bit         req_rand  = 0;
  int         aw_mode   = 0;
  int         w_mode    = 0;
  int         b_mode    = 0;
  logic [1:0] bresp_fix = 2'b00;
  bit         bresp_rand = 0;
  logic [2:0] fs_once   = '0;
  bit         fs_rand   = 0;
  logic       tog       = 1'b0;

  // Reference model of the scheduler, kept at burst/phase level.
  int          m_phase;   // 0 idle, 1 address, 2 data, 3 response
  int          m_owner;
  int          m_last;
  int          m_beat;
  int          m_bursts = 0;
  logic [31:0] m_ptr [3];
  bit          m_pend [3];
  logic        m_err;

  logic [31:0] aw_addr_q [$];
  logic [2:0]  aw_gnt_q [$];
  int          rd_cnt1, wlast_hs_cnt, wlast_beat, err_cnt;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_owner = -1;
    m_last  = 2;
    m_beat  = 0;
    m_err   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      m_ptr[i]  = '0;
      m_pend[i] = 0;
    end
  endtask

  function automatic logic pick(input int mode, input logic t);
    case (mode)
      0:       return 1'b1;
      1:       return t;
      default: return 1'($urandom_range(0, 1));
    endcase
  endfunction

  task automatic drive_inputs();
    logic [2:0] fs;
    ch_req = req_rand ? 3'($urandom_range(0, 7)) : req_fix;
    fs = fs_once;
    fs_once = '0;
    if (fs_rand && ($urandom_range(0, 19) == 0)) fs[$urandom_range(0, 2)] = 1'b1;
    ch_frame_start = fs;
    for (int i = 0; i < 3*DW/32; i++) ch_data[i*32 +: 32] = $urandom;
    tog = ~tog;
    awready = pick(aw_mode, tog);
    wready  = pick(w_mode, tog);
    bvalid  = pick(b_mode, tog);
    bresp   = bresp_rand ? 2'($urandom_range(0, 3)) : bresp_fix;
  endtask

  task automatic check_model();
    logic [2:0] exp_gnt;
    logic       new_err;
    if (!rst_n) begin
      chk("rst_grant", 128'(grant), 128'(0));
      chk("rst_awvalid", 128'(awvalid), 128'(0));
      chk("rst_wvalid", 128'(wvalid), 128'(0));
      chk("rst_wlast", 128'(wlast), 128'(0));
      chk("rst_bready", 128'(bready), 128'(0));
      chk("rst_rd_en", 128'(ch_rd_en), 128'(0));
      chk("rst_wr_err", 128'(wr_err), 128'(0));
      model_reset();
      return;
    end
    exp_gnt = (m_phase == 0) ? 3'b000 : 3'(1 << m_owner);
    chk("grant", 128'(grant), 128'(exp_gnt));
    chk("awvalid", 128'(awvalid), 128'(m_phase == 1));
    chk("wvalid", 128'(wvalid), 128'(m_phase == 2));
    chk("wlast", 128'(wlast), 128'((m_phase == 2) && (m_beat == BL-1)));
    chk("bready", 128'(bready), 128'(m_phase == 3));
    chk("rd_en", 128'(ch_rd_en), 128'(((m_phase == 2) && wready) ? exp_gnt : 3'b000));
    chk("wr_err", 128'(wr_err), 128'(m_err));
    if (m_phase == 1)
      chk("awaddr", 128'(awaddr), 128'(BASE + STRIDE * 32'(m_owner) + m_ptr[m_owner]));
    if (m_phase == 2)
      chk("wdata", 128'(wdata), 128'(ch_data[m_owner*DW +: DW]));

    rd_cnt1 += int'(ch_rd_en[1]);
    if (wlast && wvalid && wready) begin
      wlast_hs_cnt++;
      wlast_beat = rd_cnt1;
    end
    err_cnt += int'(wr_err);
    if ((m_phase == 1) && awready) begin
      aw_addr_q.push_back(awaddr);
      aw_gnt_q.push_back(grant);
    end

    new_err = 1'b0;
    for (int n = 0; n < 3; n++) begin
      if (ch_frame_start[n]) begin
        if ((m_phase != 0) && (m_owner == n)) m_pend[n] = 1;
        else                                  m_ptr[n]  = '0;
      end
    end
    case (m_phase)
      0: if (ch_req != 3'b000) begin
        for (int k = 1; k <= 3; k++) begin
          if (ch_req[(m_last + k) % 3] && (m_phase == 0)) begin
            m_owner = (m_last + k) % 3;
            m_phase = 1;
          end
        end
        m_last = m_owner;
      end
      1: if (awready) begin
        m_phase = 2;
        m_beat  = 0;
      end
      2: if (wready) begin
        if (m_beat == BL-1) m_phase = 3;
        else                m_beat++;
      end
      default: if (bvalid) begin
        new_err = (bresp != 2'b00);
        if (m_pend[m_owner]) m_ptr[m_owner] = '0;
        else                 m_ptr[m_owner] = (m_ptr[m_owner] + BYTES) % STRIDE;
        m_pend[m_owner] = 0;
        m_phase = 0;
        m_owner = -1;
        m_bursts++;
      end
    endcase
    m_err = new_err;
  endtask

  task automatic cycle();
    drive_inputs();
    @(negedge clk);
    check_model();
    @(posedge clk);
    #1;
  endtask

  task automatic run_bursts(input int n, input int budget);
    int target = m_bursts + n;
    int cnt = 0;
    while ((m_bursts < target) && (cnt < budget)) begin
      cycle();
      cnt++;
    end
    chk("burst_budget", 128'(m_bursts), 128'(target));
  endtask

  task automatic clear_logs();
    aw_addr_q.delete();
    aw_gnt_q.delete();
    rd_cnt1 = 0;
    wlast_hs_cnt = 0;
    wlast_beat = 0;
    err_cnt = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int k;
    model_reset();
    clear_logs();
    rst_n = 1'b0;

    // Reset state and constant outputs
    for (int i = 0; i < 3; i++) cycle();
    chk("awlen", 128'(awlen), 128'(BL - 1));
    chk("wstrb", 128'(wstrb), 128'({(DW/8){1'b1}}));
    rst_n = 1'b1;

    // All channels requesting, everything ready: rotation and channel 0 addresses
    req_fix = 3'b111;
    clear_logs();
    run_bursts(4, 400);
    chk("rr_count", 128'(aw_gnt_q.size()), 128'(4));
    chk("rr_g0", 128'(aw_gnt_q[0]), 128'(3'b001));
    chk("rr_g1", 128'(aw_gnt_q[1]), 128'(3'b010));
    chk("rr_g2", 128'(aw_gnt_q[2]), 128'(3'b100));
    chk("rr_g3", 128'(aw_gnt_q[3]), 128'(3'b001));
    chk("ch0_addr_a", 128'(aw_addr_q[0]), 128'(32'h10000000));
    chk("ch1_addr_a", 128'(aw_addr_q[1]), 128'(BASE + STRIDE));
    chk("ch2_addr_a", 128'(aw_addr_q[2]), 128'(BASE + 2*STRIDE));
    chk("ch0_addr_b", 128'(aw_addr_q[3]), 128'(32'h10000200));

    // Channel 1 alone with WREADY toggling
    req_fix = 3'b010;
    w_mode = 1;
    clear_logs();
    run_bursts(1, 300);
    chk("ch1_pops", 128'(rd_cnt1), 128'(32));
    chk("wlast_count", 128'(wlast_hs_cnt), 128'(1));
    chk("wlast_beat", 128'(wlast_beat), 128'(32));
    chk("ch1_addr", 128'(aw_addr_q[0]), 128'(BASE + STRIDE + BYTES));
    w_mode = 0;

    // Frame restart on channel 0 mid-burst, and on idle channel 1 at the same time
    req_fix = 3'b001;
    k = 0;
    while (!((m_phase == 2) && (m_owner == 0) && (m_beat == 5)) && (k < 200)) begin
      cycle();
      k++;
    end
    chk("reach_ch0_w", 128'(m_phase), 128'(2));
    fs_once = 3'b011;
    run_bursts(1, 200);
    clear_logs();
    run_bursts(1, 200);
    chk("fs_ch0_addr", 128'(aw_addr_q[0]), 128'(32'h10000000));

    // Channel 2 pointer wrap at the stride
    req_fix = 3'b100;
    k = 0;
    while ((m_ptr[2] != STRIDE - BYTES) && (k < 16)) begin
      run_bursts(1, 200);
      k++;
    end
    clear_logs();
    run_bursts(2, 400);
    chk("wrap_pre", 128'(aw_addr_q[0]), 128'(BASE + 3*STRIDE - BYTES));
    chk("wrap_post", 128'(aw_addr_q[1]), 128'(BASE + 2*STRIDE));

    // Error response on channel 1: single pulse, pointer still advances
    req_fix = 3'b010;
    bresp_fix = 2'b10;
    clear_logs();
    run_bursts(1, 200);
    bresp_fix = 2'b00;
    run_bursts(1, 200);
    chk("err_pulses", 128'(err_cnt), 128'(1));
    chk("err_addr_a", 128'(aw_addr_q[0]), 128'(BASE + STRIDE));
    chk("err_addr_b", 128'(aw_addr_q[1]), 128'(BASE + STRIDE + BYTES));

    // Random traffic, backpressure, responses and frame restarts
    req_rand = 1;
    aw_mode = 2;
    w_mode = 2;
    b_mode = 2;
    bresp_rand = 1;
    fs_rand = 1;
    run_bursts(25, 4000);
    req_rand = 0;
    aw_mode = 0;
    w_mode = 0;
    b_mode = 0;
    bresp_rand = 0;
    fs_rand = 0;

    // Asynchronous reset at beat 10, then first grant after release
    req_fix = 3'b111;
    k = 0;
    while (!((m_phase == 2) && (m_beat == 10)) && (k < 300)) begin
      cycle();
      k++;
    end
    chk("reach_beat10", 128'(m_beat), 128'(10));
    wready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("async_grant", 128'(grant), 128'(0));
    chk("async_awvalid", 128'(awvalid), 128'(0));
    chk("async_wvalid", 128'(wvalid), 128'(0));
    chk("async_wlast", 128'(wlast), 128'(0));
    chk("async_bready", 128'(bready), 128'(0));
    chk("async_rd_en", 128'(ch_rd_en), 128'(0));
    chk("async_wr_err", 128'(wr_err), 128'(0));
    for (int i = 0; i < 3; i++) cycle();
    rst_n = 1'b1;
    clear_logs();
    run_bursts(1, 200);
    chk("post_rst_grant", 128'(aw_gnt_q[0]), 128'(3'b001));
    chk("post_rst_addr", 128'(aw_addr_q[0]), 128'(BASE));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/stitch_wr_scheduler.md
STITCH_WR_SCHEDULER -- requirements
Module: stitch_wr_scheduler

Interface
REQ-001 SHALL have parameter BURST_LEN, default 32, AXI write burst length in beats (AWLEN = BURST_LEN-1).
REQ-002 SHALL have parameter DATA_W, default 128, AXI data width.
REQ-003 SHALL have parameter ADDR_W, default 32, AXI address width.
REQ-004 SHALL have parameter BASE_ADDR, default 32'h10000000, start of channel 0 frame buffer.
REQ-005 SHALL have parameter CH_STRIDE, default 32'h00800000, byte spacing between channel frame buffers; the channel write pointer wraps at this value.
REQ-006 Ports:
- M_AXI_ACLK  in  1  single clock.
- M_AXI_ARESETN  in  1  asynchronous active-low reset.
- ch_req  in  3  channel n FWFT FIFO holds >= BURST_LEN beats.
- ch_frame_start  in  3  one-cycle pulse, channel n frame begins (already in this clock domain).
- ch_data  in  3*DATA_W  channel n FIFO head, slice [n*DATA_W +: DATA_W].
- ch_rd_en  out  3  FIFO pop, one beat.
- M_AXI_AWADDR  out  ADDR_W  burst address.
- M_AXI_AWLEN  out  8  constant BURST_LEN-1.
- M_AXI_AWVALID / M_AXI_AWREADY  out/in  1  address handshake.
- M_AXI_WDATA  out  DATA_W  write data.
- M_AXI_WSTRB  out  DATA_W/8  all ones.
- M_AXI_WLAST  out  1  final beat.
- M_AXI_WVALID / M_AXI_WREADY  out/in  1  data handshake.
- M_AXI_BRESP  in  2  write response.
- M_AXI_BVALID / M_AXI_BREADY  in/out  1  response handshake.
- grant  out  3  one-hot owner, zero in IDLE.
- wr_err  out  1  one-cycle pulse on BRESP != OKAY.

Function
REQ-007 SHALL implement states IDLE, AW, W, B; exactly one burst outstanding at any time.
REQ-008 IDLE: if any ch_req bit is set, SHALL select round-robin starting after the last-granted channel (initial priority 0,1,2), register grant, enter AW next cycle.
REQ-009 AW: SHALL assert AWVALID with AWADDR = BASE_ADDR + n*CH_STRIDE + ptr[n]; AWADDR and AWVALID SHALL hold until AWREADY; enter W on handshake.
REQ-010 W: SHALL drive WDATA = ch_data slice of the granted channel with WVALID high; ch_rd_en[n] = WVALID & WREADY; beat counter 0..BURST_LEN-1; WLAST high when counter = BURST_LEN-1; enter B after the last-beat handshake.
REQ-011 WVALID SHALL never depend on WREADY; WREADY low SHALL stall with no pop.
REQ-012 B: BREADY high; on BVALID SHALL advance ptr[n] by BURST_LEN*DATA_W/8 modulo CH_STRIDE, pulse wr_err if BRESP != 2'b00 (pointer still advances), clear grant, return to IDLE.
REQ-013 ch_frame_start[n] with n not granted SHALL clear ptr[n] next cycle; while n is granted it SHALL set a pending flag applied, instead of the advance, at that burst's B handshake.
REQ-014 ch_req deassertion after grant SHALL not abort the burst.
REQ-015 Minimum IDLE dwell is one cycle between bursts.

Reset
REQ-016 Asynchronous assertion of M_AXI_ARESETN low SHALL immediately force state IDLE, grant 0, AWVALID 0, WVALID 0, WLAST 0, BREADY 0, ch_rd_en 0, wr_err 0, ptr[0..2] 0, pending flags 0, round-robin pointer to channel 2 (channel 0 next); release is synchronous to M_AXI_ACLK.
REQ-017 Reset mid-burst SHALL abandon the burst with no further pops.

Structure
REQ-018 AXI response codes, state encoding and channel count (3) SHALL live in shared package stitch_pkg.
REQ-019 A sub-module rr_arbiter3 (request in, one-hot grant out, update enable) SHALL implement the round-robin selection.

Verification
REQ-020 ch_req=3'b111 held, AW/W/B always ready -> grants 001,010,100,001; channel 0 addresses 32'h10000000 then 32'h10000200.
REQ-021 Single channel 1, WREADY toggling every cycle -> exactly 32 ch_rd_en[1] pulses, WLAST on beat 32 only, AWADDR 32'h10800000.
REQ-022 ch_frame_start[0] during channel 0 W state -> following burst's AWADDR 32'h10000000.
REQ-023 ptr[2] = 32'h007FFE00, one burst -> ptr[2] wraps to 0; next AWADDR 32'h11000000.
REQ-024 BRESP=2'b10 -> one-cycle wr_err, pointer still advances by 32'h200.
REQ-025 Reset asserted at beat 10 -> all outputs zero asynchronously; first post-reset grant goes to channel 0.
